fp_mul_seq: RTL and testbench

- Parametrised, handshaked, multi-cycle IEEE-754 multiplier. Successor to the combinational single-cycle multiplier in the ALU.
- Uses an iterative shift-add mantissa engine instead of a full-width array multiplier, which trades latency for area.
- Adds NaN/infinity handling, signed-zero results, overflow/underflow flags and valid/ready flow control.
- Sits between the ALU operand registers and the result writeback.

---
 rtl/fp_mul_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: handshaked multi-cycle IEEE-754 multiplier built on a shift-add mantissa engine.
// Optional macro FP_MUL_ROUND_EN selects round-to-nearest-even; otherwise results are truncated.
module fp_mul_seq #(
    parameter int N = 32,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_ovf,
    output logic         flag_unf,
    output logic         flag_nan
);
    localparam int F    = N - M - 1;
    localparam int W    = 2 * (F + 1);
    localparam int CW   = $clog2(F + 1);
    localparam int BIAS = 2 ** (M - 1) - 1;
    localparam int EMAX = 2 ** M - 1;

    localparam logic signed [M+1:0] BIAS_S   = (M+2)'(BIAS);
    localparam logic signed [M+1:0] EMAX_S   = (M+2)'(EMAX);
    localparam logic signed [M+1:0] ZERO_S   = {(M+2){1'b0}};
    localparam logic signed [M+1:0] ONE_S    = {{(M+1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]       CNT_LAST = CW'(F);
    localparam logic [CW-1:0]       CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]        QNAN     = {1'b0, {M{1'b1}}, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic exp_ones(input logic [M-1:0] e);
        return &e;
    endfunction

    function automatic logic exp_zero(input logic [M-1:0] e);
        return ~|e;
    endfunction

    function automatic logic frac_nz(input logic [F-1:0] f);
        return |f;
    endfunction

    state_t state_q, state_d;
    logic                  sign_q, sign_d;
    logic [F:0]            mcand_q, mcand_d;
    logic [W-1:0]          acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [M+1:0]   exp_q, exp_d;
    logic [N-1:0]          result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  nan_q, nan_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;

    logic [M-1:0]          ea_s, eb_s;
    logic [F-1:0]          fa_s, fb_s;
    logic                  a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    logic                  a_zero_s, b_zero_s, a_sub_s, b_sub_s;
    logic                  sign_s;
    logic [F+1:0]          sum_s;
    logic [F-1:0]          frac_s, frac_r_s;
    logic signed [M+1:0]   exp_n_s, exp_r_s;
    logic [N-1:0]          pack_s;
    logic                  pk_ovf_s, pk_unf_s;

    assign ea_s     = a[N-2:F];
    assign eb_s     = b[N-2:F];
    assign fa_s     = a[F-1:0];
    assign fb_s     = b[F-1:0];
    assign a_nan_s  = exp_ones(ea_s) & frac_nz(fa_s);
    assign b_nan_s  = exp_ones(eb_s) & frac_nz(fb_s);
    assign a_inf_s  = exp_ones(ea_s) & ~frac_nz(fa_s);
    assign b_inf_s  = exp_ones(eb_s) & ~frac_nz(fb_s);
    assign a_zero_s = exp_zero(ea_s);
    assign b_zero_s = exp_zero(eb_s);
    assign a_sub_s  = a_zero_s & frac_nz(fa_s);
    assign b_sub_s  = b_zero_s & frac_nz(fb_s);
    assign sign_s   = a[N-1] ^ b[N-1];

    // Leading-one select: product lies in [1,4), so the fraction starts below bit 2F+1 or 2F.
    always_comb begin
        if (acc_q[W-1]) begin
            frac_s  = acc_q[2*F:F+1];
            exp_n_s = exp_q + ONE_S;
        end else begin
            frac_s  = acc_q[2*F-1:F];
            exp_n_s = exp_q;
        end
    end

`ifdef FP_MUL_ROUND_EN
    logic       guard_s, sticky_s, inc_s;
    logic [F:0] rnd_s;

    // Round to nearest even; a carry out of the fraction means the mantissa reached 2.0.
    always_comb begin
        if (acc_q[W-1]) begin
            guard_s  = acc_q[F];
            sticky_s = |acc_q[F-1:0];
        end else begin
            guard_s  = acc_q[F-1];
            sticky_s = |acc_q[F-2:0];
        end
        inc_s = guard_s & (sticky_s | frac_s[0]);
        rnd_s = {1'b0, frac_s} + {{F{1'b0}}, inc_s};
        if (rnd_s[F]) begin
            frac_r_s = {F{1'b0}};
            exp_r_s  = exp_n_s + ONE_S;
        end else begin
            frac_r_s = rnd_s[F-1:0];
            exp_r_s  = exp_n_s;
        end
    end
`else
    // Truncation: bits below the fraction are simply dropped.
    always_comb begin
        frac_r_s = frac_s;
        exp_r_s  = exp_n_s;
    end
`endif

    // Range check of the rounded exponent and packing of the normal-path result.
    always_comb begin
        if (exp_r_s >= EMAX_S) begin
            pack_s   = {sign_q, {M{1'b1}}, {F{1'b0}}};
            pk_ovf_s = 1'b1;
            pk_unf_s = 1'b0;
        end else if (exp_r_s <= ZERO_S) begin
            pack_s   = {sign_q, {(N-1){1'b0}}};
            pk_ovf_s = 1'b0;
            pk_unf_s = 1'b1;
        end else begin
            pack_s   = {sign_q, exp_r_s[M-1:0], frac_r_s};
            pk_ovf_s = 1'b0;
            pk_unf_s = 1'b0;
        end
    end

    // Next-state and datapath control for IDLE/MUL/NORM/DONE.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        nan_d    = nan_q;
        sum_s    = {1'b0, acc_q[W-1:F+1]};
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = sign_s;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    nan_d  = 1'b0;
                    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
                        state_d  = S_DONE;
                        result_d = QNAN;
                        nan_d    = 1'b1;
                    end else if (a_inf_s || b_inf_s) begin
                        state_d  = S_DONE;
                        result_d = {sign_s, {M{1'b1}}, {F{1'b0}}};
                    end else if (a_zero_s || b_zero_s) begin
                        state_d  = S_DONE;
                        result_d = {sign_s, {(N-1){1'b0}}};
                        unf_d    = a_sub_s | b_sub_s;
                    end else begin
                        // The multiplier rides in the low half of the accumulator and is shifted out as product bits enter.
                        state_d = S_MUL;
                        mcand_d = {1'b1, fa_s};
                        acc_d   = {{(F+1){1'b0}}, 1'b1, fb_s};
                        cnt_d   = {CW{1'b0}};
                        exp_d   = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (acc_q[0]) begin
                    sum_s = {1'b0, acc_q[W-1:F+1]} + {1'b0, mcand_q};
                end else begin
                    sum_s = {1'b0, acc_q[W-1:F+1]};
                end
                acc_d = {sum_s, acc_q[F:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_NORM: begin
                state_d  = S_DONE;
                result_d = pack_s;
                ovf_d    = pk_ovf_s;
                unf_d    = pk_unf_s;
                nan_d    = 1'b0;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    nan_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset discards any product in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q      <= 1'b0;
            mcand_q     <= {(F+1){1'b0}};
            acc_q       <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            exp_q       <= ZERO_S;
            result_q    <= {N{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;
    assign flag_nan  = nan_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed vectors push expectations, a negedge monitor pops and compares.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        in_ready, out_valid, flag_ovf, flag_unf, flag_nan;
    logic [31:0] result;

    fp_mul_seq #(.N(32), .M(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_nan(flag_nan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef FP_MUL_ROUND_EN
    localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
    localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int outs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: first cycle of each out_valid pops the scoreboard; later cycles check stability.
    logic        seen = 1'b0;
    logic [31:0] held_res;
    logic [2:0]  held_fl;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (out_valid) begin
            chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
            if (!seen) begin
                outs++;
                held_res = result;
                held_fl  = {flag_ovf, flag_unf, flag_nan};
                chk("sb_nonempty", {31'b0, (sb_q.size() != 0)}, 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("result", result, mon_e.res);
                    chk("flags_ovf_unf_nan", {29'b0, flag_ovf, flag_unf, flag_nan}, {29'b0, mon_e.fl});
                    chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                end
            end else begin
                chk("hold_result", result, held_res);
                chk("hold_flags", {29'b0, flag_ovf, flag_unf, flag_nan}, {29'b0, held_fl});
            end
        end
        seen = out_valid;
    end

    // Called on a negedge; returns the cycle count right after the accept edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] er,
                         input logic [2:0] efl, input int elat, input bit push, output int acc_cyc);
        int   n;
        exp_t e;
        n = 0;
        acc_cyc = -1;
        a = ia;
        b = ib;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", {31'b0, in_ready}, 32'd1);
        if (in_ready) begin
            acc_cyc = cyc + 1;
            if (push) begin
                e.res = er;
                e.fl  = efl;
                e.lat = elat;
                e.acc = acc_cyc;
                sb_q.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!in_ready || sb_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_time", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int t1, t2, t3, nb, outs_before;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'b0, flag_ovf, flag_unf, flag_nan}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Normal path, back-to-back to measure throughput.
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 1'b1, t1);
        issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 1'b1, t2);
        chk("throughput", 32'(t2 - t1), 32'd27);
        issue(32'h3F800001, 32'h3FC00000, TIE_RES,      3'b000, 26, 1'b1, t3);
        issue(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 26, 1'b1, t3);
        issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 26, 1'b1, t3);
        issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 26, 1'b1, t3);
        issue(32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 26, 1'b1, t3);

        // Special path.
        issue(32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b001, 1, 1'b1, t3);
        issue(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1, 1'b1, t3);
        issue(32'h00000001, 32'h3F800000, 32'h00000000, 3'b010, 1, 1'b1, t3);
        issue(32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 1, 1'b1, t3);
        issue(32'hFFC12345, 32'h3F800000, 32'h7FC00000, 3'b001, 1, 1'b1, t3);
        wait_idle();

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        out_ready = 1'b0;
        outs_before = outs;
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 1'b1, t3);
        nb = 0;
        while (!out_valid && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_still_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_single_accept", {31'b0, out_valid}, 32'd0);
        chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
        chk("bp_one_output", 32'(outs - outs_before), 32'd1);

        // Reset during MUL aborts the operation.
        issue(32'h40000000, 32'h40400000, 32'h0, 3'b000, 26, 1'b0, t3);
        repeat (5) @(negedge clk);
        outs_before = outs;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_result", result, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("abort_no_output", 32'(outs - outs_before), 32'd0);

        // One more normal product after the abort.
        issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 1'b1, t3);
        wait_idle();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
